// File: rtl/master_rx_burst_port_if.sv
// Bus and core-side signal bundle for the burst receive port.
// The master modport is the receive port's own view; the slave modport is
// the view of whatever drives the bus and the core (slave device plus core).
interface master_rx_burst_port_if #(
  parameter int WORD_SIZE  = 8,
  parameter int BURST_W    = 15,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 4
);
  logic [LANES-1:0]                     rx_data;
  logic                                 s_valid;
  logic                                 tx_done;
  logic [1:0]                           instruction;
  logic [BURST_W-1:0]                   burst_size;
  logic                                 abort;
  logic                                 data_ready;
  logic                                 m_ready;
  logic                                 rx_done;
  logic                                 busy;
  logic [WORD_SIZE-1:0]                 data_out;
  logic                                 data_valid;
  logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level;

  modport master (
    input  rx_data, s_valid, tx_done, instruction, burst_size, abort, data_ready,
    output m_ready, rx_done, busy, data_out, data_valid, fifo_level
  );

  modport slave (
    output rx_data, s_valid, tx_done, instruction, burst_size, abort, data_ready,
    input  m_ready, rx_done, busy, data_out, data_valid, fifo_level
  );
endinterface

// File: rtl/master_rx_burst_port.sv
// Master-side serial burst receiver: per-word m_ready/s_valid handshake,
// LANES bits per beat, words collected into a show-ahead FIFO for the core.
module master_rx_burst_port #(
  parameter int WORD_SIZE  = 8,
  parameter int BURST_W    = 15,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  master_rx_burst_port_if.master bus
);

  localparam int N      = WORD_SIZE / LANES;
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, WAIT_HS, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [BURST_W-1:0]   rem;
  logic [BURST_W-1:0]   word_cnt;
  logic [BEAT_W-1:0]    beat;
  logic [WORD_SIZE-1:0] word_p0;
  logic [WORD_SIZE-1:0] word_asm;
  logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     count;
  logic [WORD_SIZE-1:0] hold;
  logic                 full, start, hs, push, pop, last_beat, last_word;

  assign full      = (count == LVL_W'(FIFO_DEPTH));
  assign start     = (state == IDLE) && (bus.instruction == 2'b11) && bus.tx_done;
  assign hs        = bus.m_ready && bus.s_valid;
  assign last_beat = (beat == LAST_BEAT);
  // Abort wins over the final beat: a cancelled word never reaches the FIFO.
  assign push      = (state == SHIFT) && last_beat && !bus.abort;
  assign pop       = (count != '0) && bus.data_ready;
  assign last_word = ((word_cnt + BURST_W'(1)) == rem);

  // Handshake is withheld while full, so a reserved push always has a slot.
  assign bus.m_ready    = (state == WAIT_HS) && !full;
  assign bus.rx_done    = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.data_valid = (count != '0);
  assign bus.fifo_level = count;
  // When empty, show the last word delivered rather than a stale slot.
  assign bus.data_out   = (count != '0) ? mem[rd_ptr] : hold;

  // Merge the current beat into the partially assembled word.
  always_comb begin
    word_asm = word_p0;
    for (int k = 0; k < N; k++) begin
      if (beat == BEAT_W'(k)) begin
        if (MSB_FIRST != 0) word_asm[WORD_SIZE-(k+1)*LANES +: LANES] = bus.rx_data;
        else                word_asm[k*LANES +: LANES]             = bus.rx_data;
      end
    end
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (bus.burst_size == '0) ? DONE : WAIT_HS;
      WAIT_HS: if (bus.abort) state_nxt = IDLE;
               else if (hs)   state_nxt = SHIFT;
      SHIFT:   if (bus.abort) state_nxt = IDLE;
               else if (last_beat) state_nxt = last_word ? DONE : WAIT_HS;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state, burst bookkeeping and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      word_cnt <= '0;
      beat     <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        rem      <= bus.burst_size;
        word_cnt <= '0;
      end
      if (push) word_cnt <= word_cnt + BURST_W'(1);
      if (hs) beat <= '0;
      else if (state == SHIFT) beat <= last_beat ? '0 : beat + BEAT_W'(1);
    end
  end

  // ---- stage p0: word assembly and FIFO storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (state == SHIFT) word_p0 <= word_asm;
    if (push) mem[wr_ptr] <= word_asm;
  end

  // FIFO pointers, occupancy and the held output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        hold   <= mem[rd_ptr];
      end
      if (push && !pop)      count <= count + LVL_W'(1);
      else if (pop && !push) count <= count - LVL_W'(1);
    end
  end

endmodule
